clkdiv_prog: RTL and testbench

- Next-generation clock divider for the ECP3 simulation library.
- Runs on one source clock and produces:
  - a glitch-free gated copy of the clock;
  - TAPS power-of-two divided outputs;
  - one integer divide-by-D output, where D is reprogrammable at run time through a load/ack handshake.
- A synchronised RELEASE input starts and stops all outputs phase-aligned.

---
 rtl/clkdiv_prog.sv | 164 ++++++++++++++++
 tb/tb_clkdiv_prog.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clkdiv_prog.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : clkdiv_prog
//  Purpose  : Programmable clock divider. Produces a glitch-free gated copy
//             of CLKI, TAPS power-of-two divided clocks and one divide-by-D
//             clock whose divisor is reloaded through a load/ack handshake.
//             A synchronised RELEASE starts and stops all outputs in phase.
//  Revision : 1.0 - initial release
// ============================================================================
module clkdiv_prog #(
    parameter int TAPS    = 3,
    parameter int DIVW    = 4,
    parameter int DEF_DIV = 3
) (
    input  logic            CLKI,
    input  logic            RSTN,
    input  logic            RELEASE,
    input  logic            DIV_LD,
    input  logic [DIVW-1:0] DIV_IN,
    output logic            CDIV1,
    output logic [TAPS-1:0] CDIVP,
    output logic            CDIVN,
    output logic            DIV_ACK,
    output logic            RUNNING
);

    localparam logic [DIVW-1:0] c_def_div = DIVW'(DEF_DIV);
    localparam logic [DIVW-1:0] c_one     = DIVW'(1);

    typedef enum logic [0:0] {
        ST_STOP = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic            r_sync1;
    logic            r_rel_s;
    logic [TAPS-1:0] r_cnt;
    logic [DIVW-1:0] r_pc;
    logic            r_cdivn;
    logic [DIVW-1:0] r_div;
    logic            r_pend;
    logic [DIVW-1:0] r_pend_val;
    logic            r_ack;
    logic            r_run_en;

    logic            w_counting;
    logic [DIVW-1:0] w_de;
    logic [DIVW-1:0] w_half;
    logic            w_wrap;
    logic            w_apply;

    // Two-flop synchroniser for the asynchronous RELEASE request
    always_ff @(posedge CLKI or negedge RSTN) begin
        if (!RSTN) begin
            r_sync1 <= 1'b0;
            r_rel_s <= 1'b0;
        end else begin
            r_sync1 <= RELEASE;
            r_rel_s <= r_sync1;
        end
    end

    // Run/stop state register
    always_ff @(posedge CLKI or negedge RSTN) begin
        if (!RSTN) begin
            r_state <= ST_STOP;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode; counting only happens on RUN edges that stay in RUN,
    // so the STOP->RUN edge is not a counting edge and a stop clears at once
    always_comb begin
        w_state_nxt = r_state;
        w_counting  = 1'b0;
        case (r_state)
            ST_STOP: begin
                if (r_rel_s) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (r_rel_s) begin
                    w_counting = 1'b1;
                end else begin
                    w_state_nxt = ST_STOP;
                end
            end
            default: begin
                w_state_nxt = ST_STOP;
            end
        endcase
    end

    // Effective divisor treats a programmed zero as one
    always_comb begin
        w_de    = (r_div == '0) ? c_one : r_div;
        w_half  = w_de >> 1;
        w_wrap  = (r_pc == (w_de - c_one));
        w_apply = r_pend && ((r_state == ST_STOP) || (w_counting && w_wrap));
    end

    // Power-of-two counter and divide-by-D phase counter; both clear on stop
    always_ff @(posedge CLKI or negedge RSTN) begin
        if (!RSTN) begin
            r_cnt   <= '0;
            r_pc    <= '0;
            r_cdivn <= 1'b0;
        end else if (w_counting) begin
            r_cnt   <= r_cnt + TAPS'(1);
            r_cdivn <= (r_pc < w_half);
            r_pc    <= w_wrap ? '0 : (r_pc + c_one);
        end else begin
            r_cnt   <= '0;
            r_pc    <= '0;
            r_cdivn <= 1'b0;
        end
    end

    // Divisor load handshake; a new load always wins over clearing pend, so a
    // load on the apply edge stays pending for the following wrap
    always_ff @(posedge CLKI or negedge RSTN) begin
        if (!RSTN) begin
            r_div      <= c_def_div;
            r_pend     <= 1'b0;
            r_pend_val <= c_def_div;
            r_ack      <= 1'b0;
        end else begin
            r_ack <= 1'b0;
            if (w_apply) begin
                r_div <= r_pend_val;
                r_ack <= 1'b1;
            end
            if (DIV_LD) begin
                r_pend     <= 1'b1;
                r_pend_val <= DIV_IN;
            end else if (w_apply) begin
                r_pend     <= 1'b0;
            end
        end
    end

    // Gate enable changes only while CLKI is low, keeping CDIV1 glitch-free
    always_ff @(negedge CLKI or negedge RSTN) begin
        if (!RSTN) begin
            r_run_en <= 1'b0;
        end else begin
            r_run_en <= (r_state == ST_RUN);
        end
    end

    assign CDIV1   = CLKI & r_run_en;
    assign CDIVP   = r_cnt;
    assign CDIVN   = (w_de == c_one) ? CDIV1 : r_cdivn;
    assign DIV_ACK = r_ack;
    assign RUNNING = (r_state == ST_RUN);

endmodule
`default_nettype wire

// File: tb/tb_clkdiv_prog.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_clkdiv_prog
//  Purpose  : Self-checking bench for clkdiv_prog (TAPS=3, DIVW=4, DEF_DIV=3).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_clkdiv_prog;

    typedef struct packed {
        logic       run;
        logic       c1;
        logic [2:0] p;
        logic       n;
        logic       ack;
    } obs_t;

    logic       CLKI = 1'b0;
    logic       RSTN;
    logic       RELEASE;
    logic       DIV_LD;
    logic [3:0] DIV_IN;
    logic       CDIV1;
    logic [2:0] CDIVP;
    logic       CDIVN;
    logic       DIV_ACK;
    logic       RUNNING;

    int         checks = 0;
    int         errors = 0;
    obs_t       exp_q[$];
    logic [2:0] e_cnt;
    obs_t       got;
    obs_t       e;

    clkdiv_prog #(
        .TAPS    (3),
        .DIVW    (4),
        .DEF_DIV (3)
    ) u_dut (
        .CLKI    (CLKI),
        .RSTN    (RSTN),
        .RELEASE (RELEASE),
        .DIV_LD  (DIV_LD),
        .DIV_IN  (DIV_IN),
        .CDIV1   (CDIV1),
        .CDIVP   (CDIVP),
        .CDIVN   (CDIVN),
        .DIV_ACK (DIV_ACK),
        .RUNNING (RUNNING)
    );

    always #5 CLKI = ~CLKI;

    function automatic obs_t observe();
        obs_t o;
        o.run = RUNNING;
        o.c1  = CDIV1;
        o.p   = CDIVP;
        o.n   = CDIVN;
        o.ack = DIV_ACK;
        return o;
    endfunction

    function automatic obs_t mk(input logic r, input logic c, input logic [2:0] p,
                                input logic n, input logic a);
        obs_t o;
        o.run = r;
        o.c1  = c;
        o.p   = p;
        o.n   = n;
        o.ack = a;
        return o;
    endfunction

    task automatic tick();
        @(posedge CLKI);
        #1;
    endtask

    task automatic test_reset();
        RSTN    = 1'b0;
        RELEASE = 1'b0;
        DIV_LD  = 1'b0;
        DIV_IN  = 4'd0;
        for (int j = 0; j < 3; j++) begin
            if (j == 2) RSTN = 1'b1;
            exp_q.push_back(mk(0, 0, 3'd0, 0, 0));
            tick();
            got = observe();
            e   = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL reset[%0d]: got run/c1/p/n/ack=%b expected %b", j, got, e);
            end
        end
    endtask

    // RELEASE first sampled at j=0; 18 counting edges of the DEF_DIV=3 pattern
    task automatic test_startup();
        e_cnt = 3'd0;
        for (int j = 0; j < 21; j++) begin
            if (j == 0) RELEASE = 1'b1;
            if (j < 2) begin
                exp_q.push_back(mk(0, 0, 3'd0, 0, 0));
            end else if (j == 2) begin
                exp_q.push_back(mk(1, 0, 3'd0, 0, 0));
            end else begin
                e_cnt = e_cnt + 3'd1;
                exp_q.push_back(mk(1, 1, e_cnt, ((j - 3) % 3) == 0, 0));
            end
            tick();
            got = observe();
            e   = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL startup[%0d]: got run/c1/p/n/ack=%b expected %b", j, got, e);
            end
        end
    endtask

    // Load 4 at the first edge of a D=3 window; applied at that window's wrap
    task automatic test_reload();
        logic n;
        for (int j = 0; j < 15; j++) begin
            DIV_LD = (j == 0);
            DIV_IN = 4'd4;
            e_cnt  = e_cnt + 3'd1;
            if (j < 3) n = (j == 0);
            else       n = ((j - 3) % 4) < 2;
            exp_q.push_back(mk(1, 1, e_cnt, n, j == 2));
            tick();
            got = observe();
            e   = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL reload[%0d]: got run/c1/p/n/ack=%b expected %b", j, got, e);
            end
        end
        DIV_LD = 1'b0;
    endtask

    // Two loads (5 then 6) inside one D=4 window: single ack, D becomes 6
    task automatic test_back_to_back();
        logic n;
        for (int j = 0; j < 16; j++) begin
            DIV_LD = (j == 0) || (j == 2);
            DIV_IN = (j == 0) ? 4'd5 : 4'd6;
            e_cnt  = e_cnt + 3'd1;
            if (j < 4) n = (j < 2);
            else       n = ((j - 4) % 6) < 3;
            exp_q.push_back(mk(1, 1, e_cnt, n, j == 3));
            tick();
            got = observe();
            e   = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL last_wins[%0d]: got run/c1/p/n/ack=%b expected %b", j, got, e);
            end
        end
        DIV_LD = 1'b0;
    endtask

    // Load 0, later 1: CDIVN follows CDIV1 high and low
    task automatic test_div_one();
        logic n;
        for (int j = 0; j < 14; j++) begin
            DIV_LD = (j == 0) || (j == 10);
            DIV_IN = (j == 0) ? 4'd0 : 4'd1;
            e_cnt  = e_cnt + 3'd1;
            n      = (j < 3) || (j >= 5);
            exp_q.push_back(mk(1, 1, e_cnt, n, (j == 5) || (j == 11)));
            tick();
            got = observe();
            e   = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL div_one[%0d]: got run/c1/p/n/ack=%b expected %b", j, got, e);
            end
            if (j >= 6 && j <= 9) begin
                @(negedge CLKI);
                #1;
                checks++;
                if (CDIVN !== 1'b0 || CDIV1 !== 1'b0) begin
                    errors++;
                    $display("FAIL div_one_low[%0d]: got c1=%b n=%b expected c1=0 n=0", j, CDIV1, CDIVN);
                end
            end
        end
        DIV_LD = 1'b0;
    endtask

    // Stop with D=1, load 2 while stopped, restart from phase zero
    task automatic test_stop_restart();
        for (int j = 0; j < 27; j++) begin
            if (j == 0) RELEASE = 1'b0;
            if (j == 8) RELEASE = 1'b1;
            DIV_LD = (j == 5);
            DIV_IN = 4'd2;
            if (j < 2) begin
                e_cnt = e_cnt + 3'd1;
                exp_q.push_back(mk(1, 1, e_cnt, 1, 0));
            end else if (j == 2) begin
                e_cnt = 3'd0;
                exp_q.push_back(mk(0, 1, 3'd0, 1, 0));
            end else if (j < 10) begin
                exp_q.push_back(mk(0, 0, 3'd0, 0, j == 6));
            end else if (j == 10) begin
                exp_q.push_back(mk(1, 0, 3'd0, 0, 0));
            end else begin
                e_cnt = e_cnt + 3'd1;
                exp_q.push_back(mk(1, 1, e_cnt, ((j - 11) % 2) == 0, 0));
            end
            tick();
            got = observe();
            e   = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL stop_restart[%0d]: got run/c1/p/n/ack=%b expected %b", j, got, e);
            end
            if (j == 2) begin
                #3;
                checks++;
                if (CDIV1 !== 1'b1) begin
                    errors++;
                    $display("FAIL last_pulse_width: got c1=%b expected 1", CDIV1);
                end
                @(negedge CLKI);
                #1;
                checks++;
                if (CDIV1 !== 1'b0 || CDIVN !== 1'b0) begin
                    errors++;
                    $display("FAIL last_pulse_end: got c1=%b n=%b expected c1=0 n=0", CDIV1, CDIVN);
                end
            end
        end
        DIV_LD = 1'b0;
    endtask

    // Reset mid-run with a load pending: immediate clear, DEF_DIV, no ack
    task automatic test_reset_midrun();
        DIV_LD = 1'b1;
        DIV_IN = 4'd7;
        e_cnt  = e_cnt + 3'd1;
        exp_q.push_back(mk(1, 1, e_cnt, 1, 0));
        tick();
        got = observe();
        e   = exp_q.pop_front();
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL pre_reset: got run/c1/p/n/ack=%b expected %b", got, e);
        end
        DIV_LD = 1'b0;
        #2;
        RSTN = 1'b0;
        #1;
        exp_q.push_back(mk(0, 0, 3'd0, 0, 0));
        got = observe();
        e   = exp_q.pop_front();
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL async_reset: got run/c1/p/n/ack=%b expected %b", got, e);
        end
        tick();
        RSTN  = 1'b1;
        e_cnt = 3'd0;
        for (int j = 0; j < 15; j++) begin
            if (j < 2) begin
                exp_q.push_back(mk(0, 0, 3'd0, 0, 0));
            end else if (j == 2) begin
                exp_q.push_back(mk(1, 0, 3'd0, 0, 0));
            end else begin
                e_cnt = e_cnt + 3'd1;
                exp_q.push_back(mk(1, 1, e_cnt, ((j - 3) % 3) == 0, 0));
            end
            tick();
            got = observe();
            e   = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL after_reset[%0d]: got run/c1/p/n/ack=%b expected %b", j, got, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_startup();
        test_reload();
        test_back_to_back();
        test_div_one();
        test_stop_restart();
        test_reset_midrun();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no completion expected finish before 100000ns");
        $fatal(1);
    end

endmodule
`default_nettype wire
